// File: rtl/apu_pkg.sv
// apu_pkg: shared frame-sequencer constants and types
package apu_pkg;
  localparam int FS_STEPS = 8;
  localparam logic [7:0] LEN_STEP_MASK = 8'b01010101;
  localparam logic [7:0] SWEEP_STEP_MASK = 8'b01000100;
  localparam logic [7:0] ENV_STEP_MASK = 8'b10000000;
  typedef logic [2:0] fs_step_t;
endpackage

// File: rtl/fs_event_capture.sv
// fs_event_capture: DIV falling-edge detect with mode masking, power-on skip and pending latch
module fs_event_capture #(
  parameter int SEL_BIT_NORMAL = 4,
  parameter int SEL_BIT_DOUBLE = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       slow_clk_en,
  input  logic [7:0] div,
  input  logic       double_speed,
  input  logic       apu_power,
  output logic       execute
);
  logic [2:0] idx;
  logic sel, prev_sel, ds_q, power_q, pending, skip, fall, power_rise, ev;
  always_comb begin
    idx = double_speed ? 3'(SEL_BIT_DOUBLE) : 3'(SEL_BIT_NORMAL);
    sel = div[idx];
    fall = prev_sel & ~sel & (ds_q == double_speed);
    power_rise = apu_power & ~power_q;
    // a same-cycle edge at power-on is ignored; skip decides the next one
    ev = apu_power & ~power_rise & fall & ~skip;
    execute = apu_power & slow_clk_en & (pending | ev);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prev_sel <= 1'b0;
      ds_q <= 1'b0;
      power_q <= 1'b0;
      pending <= 1'b0;
      skip <= 1'b0;
    end else begin
      prev_sel <= sel;
      ds_q <= double_speed;
      power_q <= apu_power;
      if (!apu_power) begin
        pending <= 1'b0;
        skip <= 1'b0;
      end else if (power_rise) begin
        pending <= 1'b0;
        skip <= sel;
      end else begin
        pending <= (pending | ev) & ~slow_clk_en;
        if (fall && skip) skip <= 1'b0;
      end
    end
endmodule

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer: 512 Hz step counter issuing length/sweep/envelope clock enables
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int SEL_BIT_NORMAL = 4,
  parameter int SEL_BIT_DOUBLE = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       slow_clk_en,
  input  logic [7:0] div,
  input  logic       double_speed,
  input  logic       apu_power,
  output logic [2:0] step,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic       len_next_no_tick
);
  logic execute;
  fs_event_capture #(
    .SEL_BIT_NORMAL(SEL_BIT_NORMAL),
    .SEL_BIT_DOUBLE(SEL_BIT_DOUBLE)
  ) u_cap (
    .clk(clk),
    .reset_n(reset_n),
    .slow_clk_en(slow_clk_en),
    .div(div),
    .double_speed(double_speed),
    .apu_power(apu_power),
    .execute(execute)
  );
  always_comb begin
    len_tick = execute & LEN_STEP_MASK[step];
    sweep_tick = execute & SWEEP_STEP_MASK[step];
    env_tick = execute & ENV_STEP_MASK[step];
    len_next_no_tick = step[0];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) step <= '0;
    else if (!apu_power) step <= '0;
    else if (execute) step <= (step == fs_step_t'(FS_STEPS - 1)) ? '0 : step + 3'd1;
endmodule
